hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage core; successor to the single-cycle load-use stall detector. Sits beside the IF/ID and ID/EX pipeline registers and drives their write enables, the PC write enable, the ID/EX bubble and the IF/ID flush. It adds a multi-cycle load-use stall, data-memory wait freezing, taken-branch flushing and a saturating stall-cycle counter.

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core.
// Latency: control outputs are combinational from state and inputs; stall_cnt is registered (1 cycle).
// Backpressure: data-memory wait freezes every stage; load-use inserts LU_CYCLES bubbles.
//
// Ports:
//   i_clk, i_rst_n                    core clock, synchronous active-low reset
//   i_idex_memread, i_idex_rd         load in ID/EX and its destination
//   i_ifid_rs/rt, i_ifid_rs/rt_used   IF/ID source specifiers and their use flags
//   i_ifid_memwrite                   IF/ID instruction is a store (rt = store data)
//   i_branch_taken                    branch resolved taken in ID
//   i_mem_req, i_mem_ready            EX/MEM memory access and its completion
//   i_stat_clr                        clear the stall counter
//   o_pc_write, o_ifid_write, o_idex_write, o_exmem_write   pipeline write enables
//   o_idex_bubble, o_ifid_flush       NOP injection into ID/EX and IF/ID
//   o_stall_cnt                       saturating count of cycles with pc_write=0
// Optional feature: define HAZARD_STORE_FWD_EN to skip stalls on store-data-only
// dependences (the datapath forwards MEM->MEM for those).

module hazard_ctrl #(
  parameter int REG_W     = 4,
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_idex_memread,
  input  logic [REG_W-1:0] i_idex_rd,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_rs_used,
  input  logic             i_ifid_rt_used,
  input  logic             i_ifid_memwrite,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_stat_clr,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_idex_write,
  output logic             o_exmem_write,
  output logic             o_idex_bubble,
  output logic             o_ifid_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int LU_W = $clog2(LU_CYCLES) + 1;
  // Remaining stall cycles after the first one, which is spent in RUN.
  localparam logic [LU_W-1:0] LU_INIT = (LU_CYCLES > 1) ? LU_W'(LU_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ret_lu;     // state to resume after MEM_WAIT: 1 = LU_STALL, 0 = RUN
  logic [LU_W-1:0]  r_lu_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rt_chk;
  logic w_lu_hit;
  logic w_mem_wait;
  logic w_eff_lu;
  logic w_lu_stall;

`ifdef HAZARD_STORE_FWD_EN
  assign w_rt_chk = !i_ifid_memwrite;
`else
  logic w_unused_memwrite;
  assign w_unused_memwrite = i_ifid_memwrite;
  assign w_rt_chk = 1'b1;
`endif

  assign w_lu_hit = i_idex_memread && (i_idex_rd != '0) &&
                    ((i_ifid_rs_used && (i_idex_rd == i_ifid_rs)) ||
                     (i_ifid_rt_used && (i_idex_rd == i_ifid_rt) && w_rt_chk));

  assign w_mem_wait = i_mem_req && !i_mem_ready;

  // Once the freeze lifts, MEM_WAIT behaves exactly like the state it interrupted.
  assign w_eff_lu   = (r_state == ST_LU_STALL) || ((r_state == ST_MEM_WAIT) && r_ret_lu);
  assign w_lu_stall = !w_mem_wait && (w_eff_lu || w_lu_hit);

  always_comb begin
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_idex_write  = 1'b1;
    o_exmem_write = 1'b1;
    o_idex_bubble = 1'b0;
    o_ifid_flush  = 1'b0;
    if (w_mem_wait) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_write  = 1'b0;
      o_exmem_write = 1'b0;
    end else if (w_lu_stall) begin
      // A concurrent taken branch is dropped; it re-resolves after the stall.
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_bubble = 1'b1;
    end else if (i_branch_taken) begin
      o_ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_RUN;
      r_ret_lu <= 1'b0;
      r_lu_cnt <= '0;
    end else if (w_mem_wait) begin
      r_state <= ST_MEM_WAIT;
      // Only capture on entry; consecutive wait cycles keep the original return state.
      if (r_state != ST_MEM_WAIT) begin
        r_ret_lu <= (r_state == ST_LU_STALL);
      end
    end else if (w_eff_lu) begin
      if (r_lu_cnt == '0) begin
        r_state <= ST_RUN;
      end else begin
        r_state  <= ST_LU_STALL;
        r_lu_cnt <= r_lu_cnt - 1'b1;
      end
    end else if (w_lu_hit && (LU_CYCLES > 1)) begin
      r_state  <= ST_LU_STALL;
      r_lu_cnt <= LU_INIT;
    end else begin
      r_state <= ST_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_stat_clr) begin
      r_stall_cnt <= '0;
    end else if (!o_pc_write && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [5:0] E_RUN   = 6'b111100;  // {pc,ifid,idex,exmem,bubble,flush}
  localparam logic [5:0] E_STALL = 6'b001110;
  localparam logic [5:0] E_FRZ   = 6'b000000;
  localparam logic [5:0] E_BR    = 6'b111101;

  logic       clk = 1'b0;
  logic       rst_n, memread, rs_used, rt_used, memwrite, br, mreq, mrdy, sclr;
  logic [3:0] rd, rs, rt;

  always #5 clk = ~clk;

  logic        a_pc, a_if, a_id, a_ex, a_bu, a_fl;
  logic        b_pc, b_if, b_id, b_ex, b_bu, b_fl;
  logic        c_pc, c_if, c_id, c_ex, c_bu, c_fl;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0]  c_cnt;
  wire  [5:0]  a_o = {a_pc, a_if, a_id, a_ex, a_bu, a_fl};
  wire  [5:0]  b_o = {b_pc, b_if, b_id, b_ex, b_bu, b_fl};

  // a: LU_CYCLES=1, b: LU_CYCLES=3, c: LU_CYCLES=1 with a 2-bit counter
  hazard_ctrl #(.REG_W(4), .LU_CYCLES(1), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_idex_memread(memread), .i_idex_rd(rd),
    .i_ifid_rs(rs), .i_ifid_rt(rt), .i_ifid_rs_used(rs_used), .i_ifid_rt_used(rt_used),
    .i_ifid_memwrite(memwrite), .i_branch_taken(br), .i_mem_req(mreq), .i_mem_ready(mrdy),
    .i_stat_clr(sclr), .o_pc_write(a_pc), .o_ifid_write(a_if), .o_idex_write(a_id),
    .o_exmem_write(a_ex), .o_idex_bubble(a_bu), .o_ifid_flush(a_fl), .o_stall_cnt(a_cnt));

  hazard_ctrl #(.REG_W(4), .LU_CYCLES(3), .CNT_W(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_idex_memread(memread), .i_idex_rd(rd),
    .i_ifid_rs(rs), .i_ifid_rt(rt), .i_ifid_rs_used(rs_used), .i_ifid_rt_used(rt_used),
    .i_ifid_memwrite(memwrite), .i_branch_taken(br), .i_mem_req(mreq), .i_mem_ready(mrdy),
    .i_stat_clr(sclr), .o_pc_write(b_pc), .o_ifid_write(b_if), .o_idex_write(b_id),
    .o_exmem_write(b_ex), .o_idex_bubble(b_bu), .o_ifid_flush(b_fl), .o_stall_cnt(b_cnt));

  hazard_ctrl #(.REG_W(4), .LU_CYCLES(1), .CNT_W(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_idex_memread(memread), .i_idex_rd(rd),
    .i_ifid_rs(rs), .i_ifid_rt(rt), .i_ifid_rs_used(rs_used), .i_ifid_rt_used(rt_used),
    .i_ifid_memwrite(memwrite), .i_branch_taken(br), .i_mem_req(mreq), .i_mem_ready(mrdy),
    .i_stat_clr(sclr), .o_pc_write(c_pc), .o_ifid_write(c_if), .o_idex_write(c_id),
    .o_exmem_write(c_ex), .o_idex_bubble(c_bu), .o_ifid_flush(c_fl), .o_stall_cnt(c_cnt));

  typedef struct packed {
    logic       memread;
    logic [3:0] rd, rs, rt;
    logic       rs_used, rt_used, memwrite, br, mreq, mrdy;
    logic [5:0] exp;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    memread = v.memread; rd = v.rd; rs = v.rs; rt = v.rt;
    rs_used = v.rs_used; rt_used = v.rt_used; memwrite = v.memwrite;
    br = v.br; mreq = v.mreq; mrdy = v.mrdy;
  endtask

  function automatic vec_t mk(input logic m, input logic [3:0] d, input logic [3:0] s,
                              input logic [3:0] t, input logic su, input logic tu,
                              input logic mw, input logic b, input logic rq,
                              input logic ry, input logic [5:0] e);
    vec_t v;
    v = '{memread: m, rd: d, rs: s, rt: t, rs_used: su, rt_used: tu, memwrite: mw,
          br: b, mreq: rq, mrdy: ry, exp: e};
    return v;
  endfunction

  // Drive after the falling edge, sample 1ns later, then cross the rising edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
  endtask

  task automatic hazard3;   // load r3 in ID/EX, IF/ID reads r3 through rs
    drive(mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, E_STALL));
  endtask

  task automatic do_reset;
    rst_n = 1'b0; sclr = 1'b0; idle();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t vecs[15];
  int   exp_cnt;

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    vecs[1]  = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, E_STALL);  // rs hit
    vecs[2]  = mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, E_RUN);    // rs not used
    vecs[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, E_RUN);    // r0 never hazards
    vecs[4]  = mk(0, 3, 3, 3, 1, 1, 0, 0, 0, 0, E_RUN);    // not a load
    vecs[5]  = mk(1, 7, 1, 7, 1, 1, 0, 0, 0, 0, E_STALL);  // rt hit, non-store
`ifdef HAZARD_STORE_FWD_EN
    vecs[6]  = mk(1, 5, 2, 5, 1, 1, 1, 0, 0, 0, E_RUN);    // store data only: forwarded
`else
    vecs[6]  = mk(1, 5, 2, 5, 1, 1, 1, 0, 0, 0, E_STALL);
`endif
    vecs[7]  = mk(1, 5, 5, 2, 1, 1, 1, 0, 0, 0, E_STALL);  // store address dependence
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR);
    vecs[9]  = mk(1, 3, 3, 0, 1, 0, 0, 1, 0, 0, E_STALL);  // branch + lu_hit: no flush
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_BR);     // wait ends, branch resumes
    vecs[12] = mk(1, 3, 3, 0, 1, 0, 0, 1, 1, 0, E_FRZ);    // freeze beats everything
    vecs[13] = mk(1, 3, 3, 0, 1, 0, 0, 0, 1, 1, E_STALL);  // wait ends into load-use
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    rst_n = 1'b0; sclr = 1'b0; idle();
    @(negedge clk);
    do_reset();
    #1;
    chk("reset_out_a", a_o, E_RUN);
    chk("reset_out_b", b_o, E_RUN);
    chk("reset_cnt_a", a_cnt, 0);
    chk("reset_cnt_b", b_cnt, 0);
    @(negedge clk);

    // Table: single-cycle decisions on the LU_CYCLES=1 instance.
    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), a_o, vecs[i].exp);
      if (!vecs[i].exp[5]) exp_cnt++;
      tick();
    end
    #1;
    chk("table_stall_cnt", a_cnt, exp_cnt);
    @(negedge clk);

    // LU_CYCLES=3: exactly three stall cycles, then RUN.
    do_reset();
    hazard3(); #1; chk("lu3_c1", b_o, E_STALL); tick();
    idle();    #1; chk("lu3_c2", b_o, E_STALL); tick();
    #1;            chk("lu3_c3", b_o, E_STALL); tick();
    #1;            chk("lu3_run", b_o, E_RUN);
                   chk("lu3_cnt", b_cnt, 3);
    @(negedge clk);

    // Memory wait of 4 cycles in the middle of a 3-cycle load-use stall.
    do_reset();
    hazard3(); #1; chk("mw_c1", b_o, E_STALL); tick();
    idle(); mreq = 1'b1; mrdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; chk($sformatf("mw_frz%0d", k), b_o, E_FRZ); tick();
    end
    mrdy = 1'b1;
    #1; chk("mw_resume1", b_o, E_STALL); tick();
    mreq = 1'b0; mrdy = 1'b0;
    #1; chk("mw_resume2", b_o, E_STALL); tick();
    #1; chk("mw_run", b_o, E_RUN);
        chk("mw_cnt", b_cnt, 7);
    @(negedge clk);

    // Reset while in LU_STALL abandons the stall.
    do_reset();
    hazard3(); #1; chk("rst_c1", b_o, E_STALL); tick();
    idle(); rst_n = 1'b0; tick();
    rst_n = 1'b1;
    #1; chk("rst_run", b_o, E_RUN);
        chk("rst_cnt", b_cnt, 0);
    @(negedge clk);

    // 2-bit counter saturates at 3; stat_clr wins over an increment.
    do_reset();
    hazard3();
    tick(); tick();
    #1; chk("sat_2", c_cnt, 2);
    @(negedge clk);
    tick(); tick(); tick();
    #1; chk("sat_hold", c_cnt, 3);
    @(negedge clk);
    sclr = 1'b1; tick();
    sclr = 1'b0; idle();
    #1; chk("sat_clr", c_cnt, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
